// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
// The width, the state encoding and the allowed comparator latency range live here.
package sar_pkg;

    localparam int WIDTH       = 16;
    localparam int CMP_LAT_MIN = 0;
    localparam int CMP_LAT_MAX = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    // Flags are packed as {gt, lt, eq}. Only a single asserted flag is trusted.
    function automatic logic flags_valid(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Binary search for an unknown target, driven by an external magnitude comparator.
// Each bit costs one guess update plus CMP_LAT cycles of comparator latency.
//
// state  | meaning
// IDLE   | guess parked at 0, waiting for start
// WAIT   | guess held while the comparator pipeline settles
// DECIDE | flags sampled, current bit resolved
// ERROR  | unreachable in normal operation; falls back to IDLE
module sar_search
    import sar_pkg::*;
#(
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam logic [1:0]       WAIT_LOAD  = (CMP_LAT > 0) ? 2'(CMP_LAT - 1) : 2'd0;
    localparam state_e           AFTER_STEP = (CMP_LAT > 0) ? ST_WAIT : ST_DECIDE;
    localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0]       TOP_BIT    = 4'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             fin;
    logic [WIDTH-1:0] g_upd;

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        bit_d    = bit_q;
        wcnt_d   = wcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        fin      = 1'b0;
        g_upd    = guess_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    guess_d  = MSB_ONLY;
                    bit_d    = TOP_BIT;
                    busy_d   = 1'b1;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    wcnt_d   = WAIT_LOAD;
                    state_d  = AFTER_STEP;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 2'd0) state_d = ST_DECIDE;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
            ST_DECIDE: begin
                if (!flags_valid({gt, lt, eq})) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    fin      = 1'b1;
                end else if (eq) begin
                    result_d = guess_q;
                    found_d  = 1'b1;
                    fin      = 1'b1;
                end else begin
                    if (lt) g_upd[bit_q] = 1'b0;
                    if (bit_q == 4'd0) begin
                        result_d = g_upd;
                        fin      = 1'b1;
                    end else begin
                        // Trial bit for the next position goes in alongside the resolved one.
                        g_upd[bit_q - 4'd1] = 1'b1;
                        guess_d = g_upd;
                        bit_d   = bit_q - 4'd1;
                        wcnt_d  = WAIT_LOAD;
                        state_d = AFTER_STEP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                guess_d = '0;
                bit_d   = '0;
                wcnt_d  = '0;
            end
        endcase

        if (fin) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            guess_d = '0;
            bit_d   = '0;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            result_q <= '0;
            bit_q    <= '0;
            wcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            bit_q    <= bit_d;
            wcnt_q   <= wcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench: two controllers (comparator latency 0 and 2), each answered by a
// magnitude comparator model behind a matching delay line.
module tb_sar_search;
    import sar_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        fnd;
        logic        er;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        st    [2];
    logic [15:0] tgt   [2];
    logic [15:0] guess_w [2];
    logic [15:0] result_w[2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        found_w[2];
    logic        err_w  [2];
    logic        gt0, lt0, eq0;
    logic        ovr_en;
    logic [2:0]  ovr_flags;
    logic [2:0]  cmp0, cmp2_c;
    logic [2:0]  cmp2_d1 = 3'b000;
    logic [2:0]  cmp2_d2 = 3'b000;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    assign cmp0   = {tgt[0] > guess_w[0], tgt[0] < guess_w[0], tgt[0] == guess_w[0]};
    assign gt0    = ovr_en ? ovr_flags[2] : cmp0[2];
    assign lt0    = ovr_en ? ovr_flags[1] : cmp0[1];
    assign eq0    = ovr_en ? ovr_flags[0] : cmp0[0];
    assign cmp2_c = {tgt[1] > guess_w[1], tgt[1] < guess_w[1], tgt[1] == guess_w[1]};

    always @(posedge clk) begin
        cmp2_d1 <= cmp2_c;
        cmp2_d2 <= cmp2_d1;
    end

    sar_search #(.CMP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .guess(guess_w[0]),
        .gt(gt0), .lt(lt0), .eq(eq0),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
        .found(found_w[0]), .err(err_w[0])
    );

    sar_search #(.CMP_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(st[1]), .guess(guess_w[1]),
        .gt(cmp2_d2[2]), .lt(cmp2_d2[1]), .eq(cmp2_d2[0]),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
        .found(found_w[1]), .err(err_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // Target with lowest set bit k is hit by eq after 16-k guesses; zero needs all 16.
    function automatic exp_t model(input logic [15:0] t, input int lat, input int now);
        exp_t e;
        int   n;
        logic [15:0] tv;
        tv = t;
        n  = 16;
        for (int i = 15; i >= 0; i--) if (tv[i]) n = 16 - i;
        e.res = t;
        e.fnd = (t != 16'h0);
        e.er  = 1'b0;
        e.cyc = now + 1 + n * (lat + 1);
        return e;
    endfunction

    task automatic mon(input int d);
        exp_t e;
        if (done_w[d]) begin
            if (sb_size(d) == 0) begin
                check($sformatf("done_unexpected%0d", d), {31'b0, done_w[d]}, 0);
            end else begin
                if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                check($sformatf("result%0d", d), {16'b0, result_w[d]}, {16'b0, e.res});
                check($sformatf("found%0d", d), {31'b0, found_w[d]}, {31'b0, e.fnd});
                check($sformatf("err%0d", d), {31'b0, err_w[d]}, {31'b0, e.er});
                check($sformatf("busy_at_done%0d", d), {31'b0, busy_w[d]}, 0);
                check($sformatf("guess_at_done%0d", d), {16'b0, guess_w[d]}, 0);
                check($sformatf("latency%0d", d), cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    logic [15:0] prev_g = 16'h0;
    logic        prev_b = 1'b0;
    int          run = 0;
    always @(negedge clk) begin
        if (busy_w[1]) begin
            if (prev_b && guess_w[1] == prev_g) run <= run + 1;
            else begin
                if (prev_b) check("guess_hold2", run, 3);
                run <= 1;
            end
        end
        prev_g <= guess_w[1];
        prev_b <= busy_w[1];
    end

    task automatic launch_exp(input int d, input logic [15:0] t, input exp_t e);
        tgt[d] = t;
        st[d]  = 1'b1;
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic launch(input int d, input logic [15:0] t);
        launch_exp(d, t, model(t, lat_of(d), cyc));
    endtask

    task automatic wait_idle(input int d, input int budget);
        int k;
        k = 0;
        while (sb_size(d) != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb_size(d) != 0) begin
            check($sformatf("timeout%0d", d), sb_size(d), 0);
            if (d == 0) sb0.delete(); else sb1.delete();
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_guess"},  {16'b0, guess_w[d]},  0);
        check({tag, "_result"}, {16'b0, result_w[d]}, 0);
        check({tag, "_busy"},   {31'b0, busy_w[d]},   0);
        check({tag, "_done"},   {31'b0, done_w[d]},   0);
        check({tag, "_found"},  {31'b0, found_w[d]},  0);
        check({tag, "_err"},    {31'b0, err_w[d]},    0);
    endtask

    initial begin
        exp_t e;
        int   k;
        rst = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0;
        tgt[0] = 16'h0; tgt[1] = 16'h0;
        ovr_en = 1'b0; ovr_flags = 3'b000;
        repeat (2) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset2");

        st[0] = 1'b1;
        @(negedge clk);
        check("rst_over_start", {31'b0, busy_w[0]}, 0);
        st[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        launch(0, 16'h8000);
        wait_idle(0, 40);
        repeat (3) @(negedge clk);
        check("held_result0", {16'b0, result_w[0]}, 32'h8000);
        check("held_found0", {31'b0, found_w[0]}, 1);

        launch(0, 16'h0000);
        wait_idle(0, 40);
        launch(0, 16'hFFFF);
        wait_idle(0, 40);
        for (int i = 0; i < 6; i++) begin
            launch(0, 16'($urandom_range(0, 16'hFFFF)));
            wait_idle(0, 40);
        end

        // Restart in the very cycle done is high.
        launch(0, 16'h0F00);
        k = 0;
        while (!done_w[0] && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("b2b_done_seen", {31'b0, done_w[0]}, 1);
        launch(0, 16'h0003);
        wait_idle(0, 40);

        ovr_en = 1'b1;
        ovr_flags = 3'b110;
        e = '{res: 16'h0, fnd: 1'b0, er: 1'b1, cyc: cyc + 2};
        launch_exp(0, 16'h1234, e);
        wait_idle(0, 10);
        ovr_flags = 3'b000;
        e = '{res: 16'h0, fnd: 1'b0, er: 1'b1, cyc: cyc + 2};
        launch_exp(0, 16'h1234, e);
        wait_idle(0, 10);
        ovr_flags = 3'b111;
        e = '{res: 16'h0, fnd: 1'b0, er: 1'b1, cyc: cyc + 2};
        launch_exp(0, 16'h1234, e);
        wait_idle(0, 10);
        ovr_en = 1'b0;
        launch(0, 16'h4000);
        wait_idle(0, 40);

        launch(1, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            repeat (5) @(negedge clk);
            st[1] = 1'b1;
            @(negedge clk);
            st[1] = 1'b0;
        end
        wait_idle(1, 80);

        for (int i = 0; i < 3; i++) begin
            launch(1, 16'($urandom_range(0, 16'hFFFF)));
            wait_idle(1, 80);
        end

        // Abort during the bit-8 wait: the bit-8 guess lands at E+21, rst at E+22.
        launch(1, 16'hFFFF);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        sb1.delete();
        @(negedge clk);
        rst = 1'b0;
        check_zero(1, "midrst2");
        launch(1, 16'h00A5);
        wait_idle(1, 80);

        repeat (3) @(negedge clk);
        check("drain0", sb_size(0), 0);
        check("drain2", sb_size(1), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter CMP_LAT, default 0, range 0..3: cycles of latency of the external comparator from guess to flags.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin search; sampled only when idle.
REQ-005 guess  out  16  candidate value driven to the comparator b input; unknown target drives a.
REQ-006 gt  in  1  comparator flag: target > guess.
REQ-007 lt  in  1  comparator flag: target < guess.
REQ-008 eq  in  1  comparator flag: target == guess.
REQ-009 busy  out  1  search in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 result  out  16  recovered target; held until next start or rst.
REQ-012 found  out  1  result confirmed by an eq flag; held with result.
REQ-013 err  out  1  illegal flag combination seen; held with result.

Function
REQ-014 FSM states: IDLE, WAIT, DECIDE, ERROR; all outputs registered.
REQ-015 IDLE: guess=0, busy=0; start=1 at edge E -> guess=0x8000, bit index=15, busy=1, clear result/found/err, enter WAIT.
REQ-016 WAIT: guess held; wait counter counts CMP_LAT cycles, then DECIDE; with CMP_LAT=0, WAIT lasts zero cycles.
REQ-017 Flags sampled at edge E+1+CMP_LAT after each guess update; each bit costs exactly CMP_LAT+1 cycles.
REQ-018 DECIDE, flags exactly one-hot, eq=1 -> result=guess, found=1, done pulse, IDLE.
REQ-019 DECIDE, lt=1 -> clear bit i of guess; gt=1 -> keep bit i.
REQ-020 If i>0 after lt/gt: set bit i-1, i=i-1, restart WAIT.
REQ-021 If i==0 after lt/gt: result=updated guess, found=0, done pulse, IDLE.
REQ-022 Flags not exactly one-hot at the sample edge (none set, or two or more set) -> result=0, err=1, done pulse, IDLE.
REQ-023 Worst-case latency: done asserted after edge E+16*(CMP_LAT+1); eq terminates early.
REQ-024 start while busy=1 is ignored; start in the same cycle as done (FSM in IDLE) is accepted.
REQ-025 Flags are ignored outside the sample edge.
REQ-026 done is high for exactly one cycle per search; busy falls on the same edge that done rises.

Reset
REQ-027 rst=1 at any edge, including mid-search: next cycle guess=0, result=0, busy=0, done=0, found=0, err=0, wait counter=0, FSM=IDLE.
REQ-028 rst has priority over start and flags in the same cycle.

Structure
REQ-029 Package sar_pkg holds: WIDTH=16 localparam, state enum type, CMP_LAT range constants.
REQ-030 Single flat module; no sub-module. The bench instantiates the team's 16-bit magnitude comparator as the responder, registered through a CMP_LAT-deep delay line.

Verification
REQ-031 CMP_LAT=0, target 0x8000, start -> eq at first sample; done after edge E+1, result 0x8000, found=1.
REQ-032 CMP_LAT=0, target 0x0000 -> 16 lt decisions; done after edge E+16, result 0x0000, found=0, err=0.
REQ-033 CMP_LAT=0, target 0xFFFF -> 15 gt decisions, then eq on guess 0xFFFF; done after edge E+16, found=1.
REQ-034 CMP_LAT=2, target 0x1234 -> every guess stable 3 cycles; done no later than edge E+48, result 0x1234; start pulses while busy have no effect.
REQ-035 Bench forces gt=1 and lt=1 at first sample -> done pulse after edge E+1, err=1, result 0, busy 0.
REQ-036 rst pulsed during the bit-8 WAIT -> all outputs 0 the next cycle; a new start with target 0x00A5 completes with result 0x00A5.
